// File: rtl/nonce_search_ctrl.sv
// Multi-lane nonce search controller: stamps a per-lane nonce into a header template,
// feeds LANES hash cores over valid/ready and reports the first hit or range exhaustion.
// Optional hash statistics counter is built only when NONCE_STATS_EN is defined.
module nonce_search_ctrl #(
  parameter int MSG_W     = 1024,
  parameter int NONCE_W   = 64,
  parameter int NONCE_LSB = 384,
  parameter int CMP_W     = 64,
  parameter int LANES     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic [MSG_W-1:0]         header_in,
  input  logic [NONCE_W-1:0]       nonce_start,
  input  logic [NONCE_W-1:0]       nonce_limit,
  input  logic [CMP_W-1:0]         target,
  output logic [LANES-1:0]         core_valid,
  input  logic [LANES-1:0]         core_ready,
  output logic [LANES*MSG_W-1:0]   core_msg,
  input  logic [LANES-1:0]         core_done,
  input  logic [LANES*CMP_W-1:0]   core_digest,
  output logic                     busy,
  output logic                     found,
  output logic                     exhausted,
  output logic [NONCE_W-1:0]       found_nonce,
  output logic [31:0]              hash_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
  typedef enum logic [1:0] {LN_READY, LN_ISSUE, LN_WAIT} lane_state_t;

  state_t                          state, state_nx;
  lane_state_t                     lane_state [LANES];
  logic [NONCE_W-1:0]              lane_nonce [LANES];
  logic [LANES-1:0][MSG_W-1:0]     msg_q;
  logic [NONCE_W-1:0]              limit_q;
  logic [CMP_W-1:0]                target_q;
  logic                            stopped_q;

  logic [LANES-1:0]                issue_vec, wait_vec, done_ok, hit_vec;
  logic                            hit_any;
  logic [NONCE_W-1:0]              hit_nonce;
  logic [NONCE_W:0]                step_sum [LANES];
  logic [NONCE_W:0]                init_sum [LANES];
  logic [LANES-1:0]                step_retire, init_retire;
  logic                            start_go;

  function automatic logic [MSG_W-1:0] insert_nonce(input logic [MSG_W-1:0] hdr,
                                                    input logic [NONCE_W-1:0] nonce);
    logic [MSG_W-1:0] m;
    m = hdr;
    m[NONCE_LSB +: NONCE_W] = nonce;
    return m;
  endfunction

  assign start_go   = (state == S_IDLE) && start;
  assign busy       = (state != S_IDLE);
  assign core_valid = (state == S_RUN) ? issue_vec : '0;
  assign core_msg   = msg_q;

  // NOTE: every signal written in an always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    issue_vec = '0;
    wait_vec  = '0;
    done_ok   = '0;
    hit_vec   = '0;
    hit_nonce = '0;
    for (int i = 0; i < LANES; i++) begin
      issue_vec[i] = (lane_state[i] == LN_ISSUE);
      wait_vec[i]  = (lane_state[i] == LN_WAIT);
      done_ok[i]   = wait_vec[i] && core_done[i];
      hit_vec[i]   = done_ok[i] && (state == S_RUN) &&
                     (core_digest[i*CMP_W +: CMP_W] <= target_q);
    end
    // Scan downward so the lowest hitting lane is the last (winning) assignment.
    for (int i = LANES - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_nonce = lane_nonce[i];
    end
    hit_any = |hit_vec;
  end

  // One extra bit keeps the carry, so a nonce never wraps back to zero.
  always_comb begin
    step_retire = '0;
    init_retire = '0;
    for (int i = 0; i < LANES; i++) begin
      step_sum[i]    = {1'b0, lane_nonce[i]} + (NONCE_W+1)'(LANES);
      step_retire[i] = step_sum[i] > {1'b0, limit_q};
      init_sum[i]    = {1'b0, nonce_start} + (NONCE_W+1)'(i);
      init_retire[i] = init_sum[i] > {1'b0, nonce_limit};
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (hit_any || stop || ((issue_vec | wait_vec) == '0)) state_nx = S_DRAIN;
      S_DRAIN: if (wait_vec == '0) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      limit_q     <= '0;
      target_q    <= '0;
      stopped_q   <= 1'b0;
      found       <= 1'b0;
      exhausted   <= 1'b0;
      found_nonce <= '0;
    end else if (start_go) begin
      limit_q     <= nonce_limit;
      target_q    <= target;
      stopped_q   <= 1'b0;
      found       <= 1'b0;
      exhausted   <= 1'b0;
      found_nonce <= '0;
    end else begin
      if (state == S_RUN && hit_any) begin
        found       <= 1'b1;
        found_nonce <= hit_nonce;
      end
      if (state == S_RUN && stop) stopped_q <= 1'b1;
      if (state == S_DRAIN && state_nx == S_IDLE) exhausted <= !found && !stopped_q;
    end
  end

  // NOTE: the wide message registers are reset too, because core_msg is a port that
  // must read zero after reset, not just a datapath store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) begin
        lane_state[i] <= LN_READY;
        lane_nonce[i] <= '0;
      end
      msg_q <= '0;
    end else if (start_go) begin
      for (int i = 0; i < LANES; i++) begin
        lane_nonce[i] <= init_sum[i][NONCE_W-1:0];
        msg_q[i]      <= insert_nonce(header_in, init_sum[i][NONCE_W-1:0]);
        lane_state[i] <= init_retire[i] ? LN_READY : LN_ISSUE;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        unique case (lane_state[i])
          LN_ISSUE: begin
            if (core_valid[i] && core_ready[i]) lane_state[i] <= LN_WAIT;
            else if (state == S_DRAIN)          lane_state[i] <= LN_READY;
          end
          LN_WAIT: begin
            if (done_ok[i]) begin
              if (state == S_RUN && !step_retire[i]) begin
                lane_nonce[i]                      <= step_sum[i][NONCE_W-1:0];
                msg_q[i][NONCE_LSB +: NONCE_W]     <= step_sum[i][NONCE_W-1:0];
                lane_state[i]                      <= LN_ISSUE;
              end else begin
                lane_state[i] <= LN_READY;
              end
            end
          end
          default: lane_state[i] <= LN_READY;
        endcase
      end
    end
  end

`ifdef NONCE_STATS_EN
  logic [32:0] count_sum;

  always_comb begin
    count_sum = {1'b0, hash_count};
    for (int i = 0; i < LANES; i++) count_sum = count_sum + 33'(done_ok[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        hash_count <= '0;
    else if (start_go) hash_count <= '0;
    else               hash_count <= count_sum[32] ? '1 : count_sum[31:0];
  end
`else
  assign hash_count = '0;
`endif

endmodule
